cpa64_seq: RTL

CPA64_SEQ -- requirements
Module: cpa64_seq

---
 rtl/cpa64_pkg.sv | 13 +
 rtl/cpa64_seq_add32.sv | 25 ++
 rtl/cpa64_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpa64_pkg.sv
// Shared constants for the sequential 64-bit carry-propagate adder:
// datapath widths and the 2-bit FSM state encoding.
package cpa64_pkg;

  localparam int W  = 64;
  localparam int HW = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cpa64_seq_add32.sv
// 32-bit ripple/carry-propagate adder slice shared by both halves of cpa64_seq.
// T carries the nominal propagation delay for timing-annotated models only.
module cpa64_seq_add32
  import cpa64_pkg::*;
#(
  parameter real T = 0.000
) (
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  input  logic          cin,
  output logic [HW-1:0] sum,
  output logic          cout
);

  // The synthesized adder is zero-delay; a negative delay has no meaning here.
  if (T < 0.0) begin : g_neg_delay_unsupported
  end

  logic [HW:0] full_sum;

  assign full_sum    = {1'b0, a} + {1'b0, b} + {{HW{1'b0}}, cin};
  assign sum         = full_sum[HW-1:0];
  assign cout        = full_sum[HW];

endmodule

// File: rtl/cpa64_seq.sv
// Sequential 64-bit final adder for a Dadda multiplier: one 32-bit adder reused
// for the low then high half. Define CPA64_COUT_EN to expose the bit-63 carry as cout.
module cpa64_seq
  import cpa64_pkg::*;
#(
  parameter real T = 0.000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  row_s,
  input  logic [63:0]  row_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  product
`ifdef CPA64_COUT_EN
  ,
  output logic         cout
`endif
);

  logic [1:0]    state_reg;
  logic [W-1:0]  rs_reg;
  logic [W-1:0]  rc_reg;
  logic [W-1:0]  prod_reg;
  logic          carry_reg;

  logic          accept;
  logic [HW-1:0] add_a;
  logic [HW-1:0] add_b;
  logic          add_cin;
  logic [HW-1:0] add_sum;
  logic          add_cout;

  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign product   = prod_reg;

  // Operand mux: only HI works on the upper halves and consumes the saved carry.
  always_comb begin
    add_a   = rs_reg[HW-1:0];
    add_b   = rc_reg[HW-1:0];
    add_cin = 1'b0;
    if (state_reg == ST_HI) begin
      add_a   = rs_reg[W-1:HW];
      add_b   = rc_reg[W-1:HW];
      add_cin = carry_reg;
    end
  end

  cpa64_seq_add32 #(
    .T(T)
  ) u_add32 (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rs_reg    <= '0;
      rc_reg    <= '0;
      prod_reg  <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rs_reg    <= row_s;
            rc_reg    <= row_c;
            state_reg <= ST_LO;
          end
        end
        ST_LO: begin
          prod_reg[HW-1:0] <= add_sum;
          carry_reg        <= add_cout;
          state_reg        <= ST_HI;
        end
        ST_HI: begin
          prod_reg[W-1:HW] <= add_sum;
          state_reg        <= ST_DONE;
        end
        default: begin
          // DONE: product is held until the consumer takes it.
          if (out_ready) begin
            if (accept) begin
              rs_reg    <= row_s;
              rc_reg    <= row_c;
              state_reg <= ST_LO;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef CPA64_COUT_EN
  logic cout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_reg <= 1'b0;
    end else if (state_reg == ST_HI) begin
      cout_reg <= add_cout;
    end
  end

  assign cout = cout_reg;
`endif

endmodule
